sram_arbiter: RTL

SRAM_ARBITER -- requirements
Module: sram_arbiter

---
 rtl/sram_arb_pkg.sv | 24 ++
 rtl/arb_starve_ctr.sv | 44 ++++
 rtl/sram_arbiter.sv | 177 +++++++++++++++++
 3 files changed

// File: rtl/sram_arb_pkg.sv
// Shared types and constants for the two-port SRAM arbiter.
package sram_arb_pkg;

  // Which port, if any, has a read whose data returns in the next cycle
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RD_I = 2'd1,
    RD_D = 2'd2
  } owner_e;

  // Requester identity, used by the round-robin pointer
  typedef enum logic {
    PORT_I = 1'b0,
    PORT_D = 1'b1
  } port_e;

  // Active-low byte write enables all high encode a read
  localparam logic [3:0] WEB_READ = 4'hF;

  function automatic logic is_read(input logic [3:0] web);
    return web == WEB_READ;
  endfunction

endpackage

// File: rtl/arb_starve_ctr.sv
// Starvation counter for the instruction port.
// Counts consecutive D grants while I is waiting, saturating at STARVE_MAX.
// Cleared whenever I is granted or I stops requesting. When en is low the
// counter is held at zero (round-robin builds do not use it).
module arb_starve_ctr #(
  parameter int STARVE_MAX = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic i_req,
  input  logic i_gnt,
  input  logic d_gnt,
  output logic at_max
);

  localparam int CW = (STARVE_MAX < 1) ? 1 : $clog2(STARVE_MAX + 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(STARVE_MAX);

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  // Next count: clear, increment with saturation, or hold
  always_comb begin
    cnt_d = cnt_q;
    if (!en || i_gnt || !i_req) begin
      cnt_d = '0;
    end else if (d_gnt && (cnt_q != CNT_MAX)) begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  // Counter register
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign at_max = (cnt_q == CNT_MAX);

endmodule

// File: rtl/sram_arbiter.sv
// Two-port (instruction / data) arbiter in front of a single-port
// synchronous SRAM. Grants are combinational from the requests and the
// registered arbitration state; the granted access drives the SRAM pins in
// the same cycle, and read data returns to the owning port one cycle later.
//
// Build option: define ARB_RR_EN to arbitrate conflicts round-robin
// instead of data-priority with an instruction starvation guard.
module sram_arbiter
  import sram_arb_pkg::*;
#(
  parameter int AW         = 14,
  parameter int DW         = 32,
  parameter int STARVE_MAX = 4
) (
  input  logic          clk,
  input  logic          rst,
  // instruction-fetch requester
  input  logic          i_req,
  input  logic [AW-1:0] i_addr,
  input  logic [3:0]    i_web,
  input  logic [DW-1:0] i_wdata,
  output logic          i_gnt,
  output logic          i_rvalid,
  output logic [DW-1:0] i_rdata,
  // data requester
  input  logic          d_req,
  input  logic [AW-1:0] d_addr,
  input  logic [3:0]    d_web,
  input  logic [DW-1:0] d_wdata,
  output logic          d_gnt,
  output logic          d_rvalid,
  output logic [DW-1:0] d_rdata,
  // SRAM side
  output logic          sram_cs,
  output logic          sram_oe,
  output logic [3:0]    sram_web,
  output logic [AW-1:0] sram_a,
  output logic [DW-1:0] sram_di,
  input  logic [DW-1:0] sram_do
);

  owner_e        owner_q, owner_d;
  logic [AW-1:0] a_hold_q, a_hold_d;
  logic [DW-1:0] di_hold_q, di_hold_d;
  logic [DW-1:0] i_rdata_q, i_rdata_d;
  logic [DW-1:0] d_rdata_q, d_rdata_d;

  logic i_win;        // I takes the slot when both ports request
  logic starve_en;
  logic starve_at_max;

  arb_starve_ctr #(
    .STARVE_MAX(STARVE_MAX)
  ) u_starve (
    .clk   (clk),
    .rst   (rst),
    .en    (starve_en),
    .i_req (i_req),
    .i_gnt (i_gnt),
    .d_gnt (d_gnt),
    .at_max(starve_at_max)
  );

`ifdef ARB_RR_EN
  port_e last_owner_q, last_owner_d;

  // Remember which port was granted most recently
  always_comb begin
    last_owner_d = last_owner_q;
    if (i_gnt) begin
      last_owner_d = PORT_I;
    end else if (d_gnt) begin
      last_owner_d = PORT_D;
    end
  end

  // Round-robin pointer register; after reset I wins the first conflict
  always_ff @(posedge clk) begin
    if (rst) begin
      last_owner_q <= PORT_D;
    end else begin
      last_owner_q <= last_owner_d;
    end
  end

  assign starve_en = 1'b0;
  assign i_win     = (last_owner_q == PORT_D);
`else
  assign starve_en = 1'b1;
  assign i_win     = starve_at_max;
`endif

  // Grant: a lone requester always wins; on conflict the policy decides
  always_comb begin
    i_gnt = 1'b0;
    d_gnt = 1'b0;
    if (!rst) begin
      if (i_req && d_req) begin
        i_gnt = i_win;
        d_gnt = !i_win;
      end else begin
        i_gnt = i_req;
        d_gnt = d_req;
      end
    end
  end

  // SRAM pins follow the granted access; address and write data are held
  // when idle so the pins do not toggle needlessly
  always_comb begin
    sram_cs  = 1'b0;
    sram_oe  = 1'b0;
    sram_web = WEB_READ;
    sram_a   = a_hold_q;
    sram_di  = di_hold_q;
    if (rst) begin
      sram_a  = '0;
      sram_di = '0;
    end else if (i_gnt) begin
      sram_cs  = 1'b1;
      sram_oe  = is_read(i_web);
      sram_web = i_web;
      sram_a   = i_addr;
      sram_di  = i_wdata;
    end else if (d_gnt) begin
      sram_cs  = 1'b1;
      sram_oe  = is_read(d_web);
      sram_web = d_web;
      sram_a   = d_addr;
      sram_di  = d_wdata;
    end
    a_hold_d  = sram_a;
    di_hold_d = sram_di;
  end

  // Owner FSM next state: a granted read this cycle owns next cycle's data
  always_comb begin
    owner_d = IDLE;
    if (i_gnt && is_read(i_web)) begin
      owner_d = RD_I;
    end else if (d_gnt && is_read(d_web)) begin
      owner_d = RD_D;
    end
  end

  // Read return: steer SRAM data to the owner, hold the last value otherwise
  always_comb begin
    i_rvalid = !rst && (owner_q == RD_I);
    d_rvalid = !rst && (owner_q == RD_D);
    i_rdata  = i_rvalid ? sram_do : i_rdata_q;
    d_rdata  = d_rvalid ? sram_do : d_rdata_q;
    if (rst) begin
      i_rdata = '0;
      d_rdata = '0;
    end
    i_rdata_d = i_rdata;
    d_rdata_d = d_rdata;
  end

  // State registers; reset discards any read in flight
  always_ff @(posedge clk) begin
    if (rst) begin
      owner_q   <= IDLE;
      a_hold_q  <= '0;
      di_hold_q <= '0;
      i_rdata_q <= '0;
      d_rdata_q <= '0;
    end else begin
      owner_q   <= owner_d;
      a_hold_q  <= a_hold_d;
      di_hold_q <= di_hold_d;
      i_rdata_q <= i_rdata_d;
      d_rdata_q <= d_rdata_d;
    end
  end

endmodule
